// File: rtl/sliding_tile_pkg.sv
// Shared types and the reset (solved) arrangement for the sliding-tile engine.
package sliding_tile_pkg;

    localparam int MAX_N       = 8;
    localparam int MAX_TILE_W  = 6;
    localparam int MAX_BOARD_W = MAX_N * MAX_N * MAX_TILE_W;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Packed at the tile width an n x n board uses; callers slice the low bits.
    function automatic logic [MAX_BOARD_W-1:0] solved_board(input int n);
        logic [MAX_BOARD_W-1:0] b;
        logic [8:0]             bit_idx;
        int                     cells;
        int                     tw;
        b     = '0;
        cells = n * n;
        tw    = 0;
        for (int k = 0; k < MAX_TILE_W; k++)
            if ((1 << tw) < cells) tw++;
        for (int i = 0; i < MAX_N * MAX_N; i++)
            for (int k = 0; k < MAX_TILE_W; k++)
                if (i < cells - 1 && k < tw) begin
                    bit_idx    = 9'(i * tw + k);
                    b[bit_idx] = 1'(((i + 1) >> k) & 1);
                end
        return b;
    endfunction

endpackage

// File: rtl/sliding_tile_load_checker.sv
// Captures a candidate board and scans it one cell per cycle for out-of-range
// or repeated values, recording where the space (value 0) sits.
module sliding_tile_load_checker
    import sliding_tile_pkg::*;
#(
    parameter int N       = 3,
    parameter int TILE_W  = $clog2(N*N),
    parameter int COORD_W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [N*N*TILE_W-1:0] board_i,
    output logic                  last_o,
    output logic                  error_o,
    output logic [N*N*TILE_W-1:0] shadow_o,
    output logic [COORD_W-1:0]    space_row_o,
    output logic [COORD_W-1:0]    space_col_o
);
    localparam int CELLS = N * N;
    localparam int BW    = CELLS * TILE_W;

    logic [BW-1:0]      shadow_q;
    logic               scan_q;
    logic [TILE_W-1:0]  idx_q;
    logic [COORD_W-1:0] row_q, col_q;
    logic [CELLS-1:0]   seen_q;
    logic               err_q;
    logic [COORD_W-1:0] zrow_q, zcol_q;

    logic [TILE_W-1:0]  val;
    logic               out_of_range;
    logic               repeated;

    always_comb begin
        val = '0;
        for (int i = 0; i < CELLS; i++)
            if (TILE_W'(i) == idx_q) val = shadow_q[i*TILE_W +: TILE_W];
    end

    assign out_of_range = ({1'b0, val} >= (TILE_W+1)'(CELLS));
    assign repeated     = !out_of_range && seen_q[val];
    assign last_o       = scan_q && (idx_q == TILE_W'(CELLS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            scan_q   <= 1'b0;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            seen_q   <= '0;
            err_q    <= 1'b0;
            zrow_q   <= '0;
            zcol_q   <= '0;
        end else if (start_i) begin
            shadow_q <= board_i;
            scan_q   <= 1'b1;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            seen_q   <= '0;
            err_q    <= 1'b0;
        end else if (scan_q) begin
            if (out_of_range || repeated) err_q <= 1'b1;
            if (!out_of_range) seen_q[val] <= 1'b1;
            if (val == '0) begin
                zrow_q <= row_q;
                zcol_q <= col_q;
            end
            idx_q <= idx_q + 1'b1;
            if (col_q == COORD_W'(N - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
            if (last_o) scan_q <= 1'b0;
        end
    end

    assign error_o     = err_q;
    assign shadow_o    = shadow_q;
    assign space_row_o = zrow_q;
    assign space_col_o = zcol_q;

endmodule

// File: rtl/sliding_tile_param.sv
// N x N sliding-tile engine: handshaked space moves, move counting, solved
// detection and a scanned board-load path.
//
// state  | meaning
// READY  | accepting moves and loads (load wins a tie)
// CHECK  | load checker scanning the shadow board
// COMMIT | apply the scanned board or report it as bad
module sliding_tile_param
    import sliding_tile_pkg::*;
#(
    parameter int N       = 3,
    parameter int TILE_W  = $clog2(N*N),
    parameter int COORD_W = $clog2(N),
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic [1:0]            move_dir,
    output logic                  move_rejected,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [N*N*TILE_W-1:0] load_board,
    output logic                  load_done,
    output logic                  load_error,
    output logic [N*N*TILE_W-1:0] board,
    output logic [COORD_W-1:0]    space_row,
    output logic [COORD_W-1:0]    space_col,
    output logic                  solved,
    output logic [CNT_W-1:0]      move_count
);
    localparam int                     CELLS       = N * N;
    localparam int                     BW          = CELLS * TILE_W;
    localparam logic [MAX_BOARD_W-1:0] SOLVED_FULL = solved_board(N);
    localparam logic [BW-1:0]          SOLVED      = SOLVED_FULL[BW-1:0];
    localparam logic [COORD_W-1:0]     LAST_C      = COORD_W'(N - 1);

    state_e             state_q, state_d;
    logic [BW-1:0]      board_q, board_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic               solved_q, solved_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rej_q, rej_d, done_q, done_d, err_q, err_d;

    dir_e               dir;
    logic               legal;
    logic [COORD_W-1:0] tgt_row, tgt_col;
    logic [TILE_W-1:0]  sp_idx, tgt_idx, tgt_val;
    logic [BW-1:0]      moved;

    logic               chk_start, chk_last, chk_err;
    logic [BW-1:0]      chk_board;
    logic [COORD_W-1:0] chk_row, chk_col;

    assign dir = dir_e'(move_dir);

    always_comb begin
        legal   = 1'b0;
        tgt_row = row_q;
        tgt_col = col_q;
        case (dir)
            DIR_LEFT:  begin legal = (col_q != '0);     tgt_col = col_q - 1'b1; end
            DIR_RIGHT: begin legal = (col_q != LAST_C); tgt_col = col_q + 1'b1; end
            DIR_UP:    begin legal = (row_q != '0);     tgt_row = row_q - 1'b1; end
            DIR_DOWN:  begin legal = (row_q != LAST_C); tgt_row = row_q + 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

    assign sp_idx  = TILE_W'(row_q) * TILE_W'(N) + TILE_W'(col_q);
    assign tgt_idx = TILE_W'(tgt_row) * TILE_W'(N) + TILE_W'(tgt_col);

    // Space always holds 0, so the swap writes the neighbour into the space cell.
    always_comb begin
        tgt_val = '0;
        moved   = board_q;
        for (int i = 0; i < CELLS; i++)
            if (TILE_W'(i) == tgt_idx) tgt_val = board_q[i*TILE_W +: TILE_W];
        for (int i = 0; i < CELLS; i++) begin
            if (TILE_W'(i) == sp_idx)  moved[i*TILE_W +: TILE_W] = tgt_val;
            if (TILE_W'(i) == tgt_idx) moved[i*TILE_W +: TILE_W] = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        rej_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        chk_start  = 1'b0;
        load_ready = 1'b0;
        move_ready = 1'b0;
        case (state_q)
            ST_READY: begin
                load_ready = 1'b1;
                move_ready = !load_valid;
                if (load_valid) begin
                    chk_start = 1'b1;
                    state_d   = ST_CHECK;
                end else if (move_valid) begin
                    if (legal) begin
                        board_d = moved;
                        row_d   = tgt_row;
                        col_d   = tgt_col;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (chk_last) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_READY;
                if (chk_err) begin
                    err_d = 1'b1;
                end else begin
                    board_d = chk_board;
                    row_d   = chk_row;
                    col_d   = chk_col;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    assign solved_d = (board_d == SOLVED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_READY;
            board_q  <= SOLVED;
            row_q    <= LAST_C;
            col_q    <= LAST_C;
            solved_q <= 1'b1;
            cnt_q    <= '0;
            rej_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            row_q    <= row_d;
            col_q    <= col_d;
            solved_q <= solved_d;
            cnt_q    <= cnt_d;
            rej_q    <= rej_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    sliding_tile_load_checker #(
        .N       (N),
        .TILE_W  (TILE_W),
        .COORD_W (COORD_W)
    ) u_checker (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (chk_start),
        .board_i     (load_board),
        .last_o      (chk_last),
        .error_o     (chk_err),
        .shadow_o    (chk_board),
        .space_row_o (chk_row),
        .space_col_o (chk_col)
    );

    assign board         = board_q;
    assign space_row     = row_q;
    assign space_col     = col_q;
    assign solved        = solved_q;
    assign move_count    = cnt_q;
    assign move_rejected = rej_q;
    assign load_done     = done_q;
    assign load_error    = err_q;

endmodule

// File: tb/tb_sliding_tile_param.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor pops
// and compares them whenever the engine reports a move or load outcome.
module tb_sliding_tile_param;

    localparam int K_MOK = 0, K_REJ = 1, K_LOK = 2, K_LERR = 3;
    localparam logic [1:0] DL = 2'b00, DR = 2'b01, DU = 2'b10, DD = 2'b11;

    // Tile i sits in hex digit i (rightmost digit is index 0).
    localparam logic [35:0] S    = 36'h087654321;
    localparam logic [35:0] B1   = 36'h807654321;
    localparam logic [35:0] DUP  = 36'h887654321;
    localparam logic [35:0] H9   = 36'h097654321;
    localparam logic [35:0] L10  = 36'h870654321;
    localparam logic [35:0] UPB  = 36'h857604321;
    localparam logic [35:0] Z    = 36'h876543210;
    localparam logic [35:0] ZD   = 36'h876540213;
    localparam logic [35:0] ZDR  = 36'h876504213;
    localparam logic [63:0] S4   = 64'h0FEDCBA987654321;
    localparam logic [63:0] L4   = 64'hF0EDCBA987654321;

    typedef struct {
        int          kind;
        logic [35:0] brd;
        int          row;
        int          col;
        int          slv;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   pend_move = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, mv_v, mv_r, mv_rej, ld_v, ld_r, ld_done, ld_err, slv3;
    logic [1:0]  mv_d, row3, col3, cnt3;
    logic [35:0] ld_b, brd3;

    sliding_tile_param #(.N(3), .CNT_W(2)) u_dut3 (
        .clk (clk), .reset_n (rst_n),
        .move_valid (mv_v), .move_ready (mv_r), .move_dir (mv_d), .move_rejected (mv_rej),
        .load_valid (ld_v), .load_ready (ld_r), .load_board (ld_b),
        .load_done (ld_done), .load_error (ld_err),
        .board (brd3), .space_row (row3), .space_col (col3),
        .solved (slv3), .move_count (cnt3)
    );

    logic        rst4_n, mv4_v, mv4_r, mv4_rej, ld4_v, ld4_r, ld4_done, ld4_err, slv4;
    logic [1:0]  mv4_d, row4, col4;
    logic [63:0] ld4_b, brd4;
    logic [15:0] cnt4;
    bit          seen4 = 1'b0;

    sliding_tile_param #(.N(4)) u_dut4 (
        .clk (clk), .reset_n (rst4_n),
        .move_valid (mv4_v), .move_ready (mv4_r), .move_dir (mv4_d), .move_rejected (mv4_rej),
        .load_valid (ld4_v), .load_ready (ld4_r), .load_board (ld4_b),
        .load_done (ld4_done), .load_error (ld4_err),
        .board (brd4), .space_row (row4), .space_col (col4),
        .solved (slv4), .move_count (cnt4)
    );

    always @(posedge clk) if (ld4_done || ld4_err) seen4 <= 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [35:0] b, input int r, input int c,
                        input int s, input int n);
        exp_t e;
        e.kind = kind; e.brd = b; e.row = r; e.col = c; e.slv = s; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("board", brd3, e.brd);
            chk("space_row", row3, e.row);
            chk("space_col", col3, e.col);
            chk("solved", slv3, e.slv);
            chk("move_count", cnt3, e.cnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pend_move) check_evt(mv_rej ? K_REJ : K_MOK);
                else if (mv_rej) chk("spurious_reject", mv_rej, 0);
                if (ld_done || ld_err) begin
                    check_evt(ld_done ? K_LOK : K_LERR);
                    chk("load_latency", cyc - acc_cyc, 10);
                end
                pend_move = mv_v && mv_r;
                if (ld_v && ld_r) acc_cyc = cyc + 1;
            end
        end
    end

    task automatic wait_move_hs();
        int n = 0;
        @(negedge clk);
        while (!mv_r && n < 40) begin @(negedge clk); n++; end
        if (!mv_r) begin
            checks++; errors++;
            $display("FAIL move_accept_timeout: got ready 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
        chk("queue_drained", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic mv(input logic [1:0] d, input int kind, input logic [35:0] b,
                      input int r, input int c, input int s, input int n);
        push(kind, b, r, c, s, n);
        mv_v = 1'b1;
        mv_d = d;
        wait_move_hs();
    endtask

    task automatic idle_drain();
        mv_v = 1'b0;
        drain();
    endtask

    task automatic ld(input logic [35:0] lb, input int kind, input logic [35:0] b,
                      input int r, input int c, input int s, input int n);
        int k = 0;
        push(kind, b, r, c, s, n);
        ld_v = 1'b1;
        ld_b = lb;
        @(negedge clk);
        while (!ld_r && k < 40) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        ld_v = 1'b0;
        @(negedge clk);
        chk("check_move_ready", mv_r, 0);
        chk("check_load_ready", ld_r, 0);
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0; mv_v = 1'b0; mv_d = 2'b00; ld_v = 1'b0; ld_b = '0;
        rst4_n = 1'b0; mv4_v = 1'b0; mv4_d = 2'b00; ld4_v = 1'b0; ld4_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        chk("rst_board", brd3, S);
        chk("rst_row", row3, 2);
        chk("rst_col", col3, 2);
        chk("rst_solved", slv3, 1);
        chk("rst_count", cnt3, 0);
        chk("rst_move_ready", mv_r, 1);
        chk("rst_load_ready", ld_r, 1);
        chk("rst_pulses", {mv_rej, ld_done, ld_err}, 0);
        chk("rst4_board", brd4, S4);
        chk("rst4_row", row4, 3);
        chk("rst4_col", col4, 3);
        chk("rst4_solved", slv4, 1);
        @(posedge clk); #1;

        mv(DR, K_REJ, S,  2, 2, 1, 0);
        mv(DL, K_MOK, B1, 2, 1, 0, 1);
        mv(DR, K_MOK, S,  2, 2, 1, 2);
        idle_drain();

        ld(DUP, K_LERR, S,  2, 2, 1, 2);
        ld(H9,  K_LERR, S,  2, 2, 1, 2);
        ld(B1,  K_LOK,  B1, 2, 1, 0, 0);

        mv(DR, K_MOK, S,  2, 2, 1, 1);
        mv(DL, K_MOK, B1, 2, 1, 0, 2);
        mv(DR, K_MOK, S,  2, 2, 1, 3);
        mv(DL, K_MOK, B1, 2, 1, 0, 3);
        mv(DR, K_MOK, S,  2, 2, 1, 3);
        mv(DL, K_MOK, B1, 2, 1, 0, 3);
        idle_drain();

        // Load and move presented together: load first, held move after it.
        push(K_LOK, L10, 2, 0, 0, 0);
        push(K_MOK, B1,  2, 1, 0, 1);
        ld_v = 1'b1; ld_b = L10;
        mv_v = 1'b1; mv_d = DR;
        @(negedge clk);
        chk("tie_move_ready", mv_r, 0);
        @(posedge clk); #1;
        ld_v = 1'b0;
        wait_move_hs();
        idle_drain();

        mv(DU, K_MOK, UPB, 1, 1, 0, 2);
        mv(DD, K_MOK, B1,  2, 1, 0, 3);
        idle_drain();
        ld(Z, K_LOK, Z, 0, 0, 0, 0);
        mv(DL, K_REJ, Z,   0, 0, 0, 0);
        mv(DU, K_REJ, Z,   0, 0, 0, 0);
        mv(DD, K_MOK, ZD,  1, 0, 0, 1);
        mv(DR, K_MOK, ZDR, 1, 1, 0, 2);
        idle_drain();

        // N=4: abandon a valid load with reset during the scan.
        ld4_v = 1'b1; ld4_b = L4;
        @(posedge clk); #1;
        ld4_v = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("n4_load_ready_in_check", ld4_r, 0);
        rst4_n = 1'b0;
        #1;
        chk("n4_abort_board", brd4, S4);
        chk("n4_abort_row", row4, 3);
        chk("n4_abort_col", col4, 3);
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("n4_no_load_pulse", seen4, 0);
        chk("n4_board_after", brd4, S4);
        chk("n4_load_ready_after", ld4_r, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
